dual_issue_queue: RTL

- Instruction buffer and pairing unit on the producer side of the dual-issue decode stage.
- Accepts up to two fetched instructions per cycle and holds them in a circular queue.
- Each cycle it presents slot 0 and slot 1 to the decode stage, which feeds the decode/execute pipeline register.
- Slot 1 is offered only when the pair is hazard-free for dual issue; flush and stall control match the decode/execute register.

---
 rtl/mips_isa_pkg.sv | 97 +++++++++
 rtl/issue_pair_check.sv | 30 +++
 rtl/dual_issue_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS opcode/funct constants, field positions and register-use decoding.
package mips_isa_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic       rs_en;
    logic [4:0] rs;
    logic       rt_en;
    logic [4:0] rt;
  } src_regs_t;

  function automatic logic [5:0] op_of(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[FN_MSB:FN_LSB];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic is_control(input logic [31:0] instr);
    logic [5:0] op;
    op = op_of(instr);
    return (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) || (op == OP_BNE) ||
           ((op == OP_RTYPE) && (funct_of(instr) == FN_JR));
  endfunction

  function automatic logic is_mem(input logic [31:0] instr);
    return (op_of(instr) == OP_LW) || (op_of(instr) == OP_SW);
  endfunction

  // Zero means "writes no register"; r0 can never create a hazard anyway.
  function automatic logic [4:0] dest_reg(input logic [31:0] instr);
    logic [4:0] d;
    d = '0;
    case (op_of(instr))
      OP_RTYPE: if (funct_of(instr) != FN_JR) d = rd_of(instr);
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: d = rt_of(instr);
      OP_JAL: d = REG_RA;
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic src_regs_t src_regs(input logic [31:0] instr);
    src_regs_t s;
    s       = '0;
    s.rs    = rs_of(instr);
    s.rt    = rt_of(instr);
    case (op_of(instr))
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
        s.rs_en = 1'b1;
        s.rt_en = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: s.rs_en = 1'b1;
      default: s = s;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// rtl/issue_pair_check.sv - Decides whether two adjacent instructions may dual-issue.
module issue_pair_check
  import mips_isa_pkg::*;
(
  input  logic [31:0] instr0_i,
  input  logic [31:0] instr1_i,
  output logic        pair_ok_o
);

  logic [4:0] dest0;
  logic [4:0] dest1;
  src_regs_t  src1;
  logic       ctl_hit;
  logic       mem_hit;
  logic       raw_hit;
  logic       waw_hit;

  always_comb begin
    dest0   = dest_reg(instr0_i);
    dest1   = dest_reg(instr1_i);
    src1    = src_regs(instr1_i);
    ctl_hit = is_control(instr0_i) || is_control(instr1_i);
    mem_hit = is_mem(instr0_i) && is_mem(instr1_i);
    raw_hit = (dest0 != 5'd0) &&
              ((src1.rs_en && (src1.rs == dest0)) || (src1.rt_en && (src1.rt == dest0)));
    waw_hit = (dest0 != 5'd0) && (dest0 == dest1);
    pair_ok_o = !(ctl_hit || mem_hit || raw_hit || waw_hit);
  end

endmodule

// File: rtl/dual_issue_queue.sv
// rtl/dual_issue_queue.sv - Circular instruction buffer presenting a hazard-checked issue pair.
module dual_issue_queue
  import mips_isa_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  input  logic [1:0]    in_valid,
  input  logic [31:0]   in_instr0,
  input  logic [31:0]   in_instr1,
  input  logic [31:0]   in_pc0,
  output logic          in_ready,
  output logic          out_valid0,
  output logic [31:0]   out_instr0,
  output logic [31:0]   out_pc0,
  output logic          out_valid1,
  output logic [31:0]   out_instr1,
  output logic [31:0]   out_pc1,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head1;
  logic [AW-1:0] tail1;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic          pair_ok;
  logic          has_two;

  assign head1   = head_q + AW'(1);
  assign tail1   = tail_q + AW'(1);
  assign has_two = count_q >= CW'(2);

  issue_pair_check u_pair_check (
    .instr0_i  (instr_q[head_q]),
    .instr1_i  (instr_q[head1]),
    .pair_ok_o (pair_ok)
  );

  assign in_ready   = count_q <= CW'(DEPTH - 2);
  assign count      = count_q;
  assign out_valid0 = count_q != '0;
  assign out_valid1 = has_two && pair_ok;
  assign out_instr0 = out_valid0 ? instr_q[head_q] : 32'd0;
  assign out_pc0    = out_valid0 ? pc_q[head_q]    : 32'd0;
  assign out_instr1 = has_two    ? instr_q[head1]  : 32'd0;
  assign out_pc1    = has_two    ? pc_q[head1]     : 32'd0;

  // 2'b10 (instr1 without instr0) is not a legal fetch pattern and pushes nothing.
  always_comb begin
    push_n = 2'd0;
    if (in_ready && !flush) begin
      case (in_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

  always_comb begin
    pop_n = 2'd0;
    if (!stall && !flush && out_valid0) pop_n = out_valid1 ? 2'd2 : 2'd1;
  end

  always_comb begin
    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (flush) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_n != 2'd0) begin
      instr_q[tail_q] <= in_instr0;
      pc_q[tail_q]    <= in_pc0;
    end
    if (!rst && push_n == 2'd2) begin
      instr_q[tail1] <= in_instr1;
      pc_q[tail1]    <= in_pc0 + 32'd4;
    end
  end

endmodule
